// File: rtl/multi_edge_detector.sv
// Multi-channel edge detector: per-channel synchroniser, debounce filter, edge qualification,
// sticky pending/overrun flags and a maskable OR-reduced interrupt.
module multi_edge_detector #(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [CHANNELS-1:0]   sig_in_i,
  input  logic [2*CHANNELS-1:0] mode_i,
  input  logic [CHANNELS-1:0]   clr_i,
  input  logic [CHANNELS-1:0]   irq_en_i,
  output logic [CHANNELS-1:0]   level_o,
  output logic [CHANNELS-1:0]   edge_pulse_o,
  output logic [CHANNELS-1:0]   pending_o,
  output logic [CHANNELS-1:0]   overrun_o,
  output logic                  irq_o
);

  localparam int unsigned CntW = $clog2(FILTER_LEN + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(FILTER_LEN - 1);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_lvl;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   event_q, event_d;
    logic                   pulse_q;
    logic                   pending_q, pending_d;
    logic                   overrun_q, overrun_d;

    assign sync_lvl = sync_q[SYNC_STAGES-1];

    always_comb begin
      cnt_d     = cnt_q;
      level_d   = level_q;
      event_d   = 1'b0;
      if (sync_lvl == level_q) begin
        cnt_d = '0;
      end else if (cnt_q == CntMax) begin
        level_d = sync_lvl;
        cnt_d   = '0;
        // mode is qualified on the edge where level itself changes
        event_d = sync_lvl ? mode_i[2*g] : mode_i[2*g+1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      // A new event beats a simultaneous clear
      pending_d = pulse_q | (pending_q & ~clr_i[g]);
      overrun_d = (pulse_q & pending_q) | (overrun_q & ~clr_i[g]);
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        sync_q    <= '0;
        cnt_q     <= '0;
        level_q   <= 1'b0;
        event_q   <= 1'b0;
        pulse_q   <= 1'b0;
        pending_q <= 1'b0;
        overrun_q <= 1'b0;
      end else begin
        sync_q    <= {sync_q[SYNC_STAGES-2:0], sig_in_i[g]};
        cnt_q     <= cnt_d;
        level_q   <= level_d;
        event_q   <= event_d;
        pulse_q   <= event_q;
        pending_q <= pending_d;
        overrun_q <= overrun_d;
      end
    end

    assign level_o[g]      = level_q;
    assign edge_pulse_o[g] = pulse_q;
    assign pending_o[g]    = pending_q;
    assign overrun_o[g]    = overrun_q;
  end

  assign irq_o = |(pending_o & irq_en_i);

endmodule

// File: doc/multi_edge_detector.md
Name: multi_edge_detector

Overview:
Parametrised multi-channel edge detector for asynchronous inputs (buttons, external strobes, sensor lines). Each channel has a synchroniser, a debounce/glitch filter and a per-channel edge mode selection (rise/fall/both/off). Each channel produces a one-cycle event pulse, a sticky pending flag with overrun tracking, and contributes to one maskable interrupt. It sits between raw pad inputs and the control/status logic that polls or takes interrupts.

Parameters:
CHANNELS, 4, number of independent input channels (>=1)
SYNC_STAGES, 2, synchroniser flops per channel (>=2)
FILTER_LEN, 4, consecutive clocks a new level must persist before it is accepted (>=1)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
sig_in  in  CHANNELS  raw asynchronous inputs
mode  in  2*CHANNELS  per-channel mode, bits [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both
clr  in  CHANNELS  per-channel clear for pending/overrun, one-cycle pulse
irq_en  in  CHANNELS  per-channel interrupt enable
level  out  CHANNELS  filtered, debounced level
edge_pulse  out  CHANNELS  one-cycle event pulse per qualified edge
pending  out  CHANNELS  sticky event flag
overrun  out  CHANNELS  sticky flag: event occurred while pending already set
irq  out  1  OR of (pending & irq_en)

Behaviour:
- Reset (async assert, sync release): all synchroniser flops, level, filter counters, edge_pulse, pending and overrun are 0. irq is therefore 0.
- Synchroniser: SYNC_STAGES flop chain per channel. sync_q = last stage.
- Filter, per channel: counter width $clog2(FILTER_LEN+1).
  - If sync_q == level, counter <= 0.
  - Otherwise, if counter == FILTER_LEN-1: level <= sync_q and counter <= 0. Else counter increments.
  - Any glitch shorter than FILTER_LEN clocks at sync_q resets the count and is never accepted.
- Edge qualification: rise = level changes 0->1; fall = level changes 1->0. Both are registered, so edge_pulse[i] is high for exactly one clock, the cycle after level changes.
  - A pulse is produced only if the current mode[i] enables that edge. mode is sampled on the same clock edge on which level changes.
  - mode 00 suppresses pulses. The filter and level keep running.
- Latency: input stable and set up before clock edge 0 -> level changes at edge SYNC_STAGES+FILTER_LEN-1 -> edge_pulse high during the cycle after edge SYNC_STAGES+FILTER_LEN. With defaults, edge_pulse is high after edge 6.
- Minimum spacing between pulses on one channel is FILTER_LEN clocks.
- pending[i]:
  - Set on the clock after edge_pulse[i]. In practice pending is registered from the same event, so it rises one cycle after edge_pulse.
  - Cleared by clr[i].
  - If set and clear occur in the same cycle, set wins and pending stays 1.
- overrun[i]:
  - Set when an event arrives while pending[i] is already 1.
  - Cleared by clr[i]. Simultaneous overrun-set and clr: set wins.
- irq: combinational OR of (pending & irq_en). No extra latency.
- Channels are fully independent. Simultaneous events on several channels are all captured.
- Reset mid-operation: all state returns to 0 immediately. In-flight filter counts are discarded. No pulse is generated by reset assertion or release.
- An input held high through reset release is treated as a genuine rising edge. level starts at 0, so a rise event appears after the normal latency.
- Counter never exceeds FILTER_LEN-1. No wrap-around is possible.

Test Plan:
- Defaults, mode=01 on ch0, sig_in[0] 0->1 set up before edge 0 and held -> level[0]=1 after edge 5; edge_pulse[0]=1 for exactly one cycle after edge 6; pending[0]=1 from the following cycle; irq=1 with irq_en[0]=1, 0 with irq_en[0]=0.
- Glitch rejection, FILTER_LEN=4: sig_in[1] high for 3 clocks then low -> level[1], edge_pulse[1] and pending[1] stay 0. A 4-clock pulse -> level rises and one rise event is produced.
- Modes on ch2, input toggled 0->1->0 (each level held 10 clocks) -> mode 01: one pulse; 10: one pulse on fall; 11: two pulses; 00: none, but level[2] still follows.
- Sticky/overrun: two qualified rises on ch3 with no clr -> pending[3]=1, overrun[3]=1. clr[3] asserted in the same cycle as a new event -> both remain 1. clr[3] alone -> both 0, irq drops the same cycle.
- Simultaneous: all 4 channels rise in the same cycle, mode=11 -> edge_pulse=4'b1111 in one cycle; pending=4'b1111.
- Reset mid-filter: assert reset_n low after 2 of 4 filter clocks -> all outputs 0. Input held high through release -> exactly one rise pulse, SYNC_STAGES+FILTER_LEN clocks after the first post-release edge.
